digit_scan_mux: RTL and testbench
=================================

Name: digit_scan_mux

Overview:
Parametrised time-multiplexing successor to the 2:1 mux. It scans N_DIGITS digit values, each DIGIT_W bits wide, onto one shared digit bus and drives one-cold active-low anode enables for a multiplexed 7-segment display.
- Adds a refresh prescaler and a per-slot dead-time to prevent ghosting.
- Digit values are double-buffered and update only at frame boundaries, so the display never tears.
- Supports per-digit blanking and optional leading-zero suppression.
- Sits between the digit-value logic and the segment decoder.

Parameters:
N_DIGITS, 4, number of digits scanned (2..8)
DIGIT_W, 4, bits per digit value
REFRESH_DIV, 100000, clock cycles per digit slot (>= 2)
DEAD_CYCLES, 1000, cycles at the start of each slot with all anodes off (0 <= DEAD_CYCLES < REFRESH_DIV)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
en  in  1  scan enable; 0 freezes all state
digits_in  in  N_DIGITS*DIGIT_W  digit k at bits [k*DIGIT_W +: DIGIT_W]; digit 0 is least significant
blank_mask  in  N_DIGITS  1 forces digit k dark
lz_suppress  in  1  1 enables leading-zero suppression
an_n  out  N_DIGITS  anode enables, active-low, at most one bit low
digit_out  out  DIGIT_W  shadow value of the current digit
digit_idx  out  $clog2(N_DIGITS)  current slot index
frame_tick  out  1  one-cycle pulse at the start of each frame

Behaviour:
- Interface: one clock `clk`. `rst` is asynchronous and active-high. All state lives in flops and is cleared asynchronously on reset.
- Reset values:
  - cnt=0, idx=0, state=BLANK.
  - an_n all ones, digit_out=0, digit_idx=0, frame_tick=0.
  - shadow digits 0, shadow mask all ones, so the first frame after reset is dark.
- Prescaler: cnt counts 0..REFRESH_DIV-1 and advances only when en=1.
  - When cnt==REFRESH_DIV-1 and en: cnt->0, idx->idx+1, idx wraps from N_DIGITS-1 to 0.
- FSM, 2 states: BLANK and ON.
  - BLANK->ON when the next cnt value equals DEAD_CYCLES. If DEAD_CYCLES==0, each slot starts directly in ON.
  - ON->BLANK on every slot change.
- Shadow load: on the edge where idx wraps to 0, shadow digits <= digits_in and shadow mask <= blank_mask. Inputs are not sampled at any other time.
- frame_tick is 1 exactly in the first cycle of slot 0, i.e. the cycle after the wrap edge. It does not fire at reset exit.
- Effective blank for digit k = shadow_mask[k] OR (lz_suppress AND k>0 AND shadow digits k..N_DIGITS-1 all zero). Digit 0 is never zero-suppressed.
- Outputs are flops aligned with the internal registers:
  - In any cycle with state==ON, idx==k and k not effectively blanked: an_n = ~(1<<k). Otherwise an_n is all ones.
  - digit_out = shadow digit[idx] and digit_idx = idx, including during BLANK, so the segment decoder settles before the anode turns on.
- en=0: cnt, idx, state and outputs hold their values. frame_tick is forced to 0 while en=0, and the pulse does not re-fire when en returns.
- Reset asserted mid-slot: all outputs go to their reset values immediately (asynchronously). Scanning restarts at slot 0 in BLANK with a dark frame.
- Width rule: cnt width is $clog2(REFRESH_DIV). Comparisons use width-matched constants with no truncation.

Decomposition:
- Shared package `display_pkg`: scan_state_t enum {BLANK, ON}; function clog2-safe IDX_W(N_DIGITS).
- Sub-module `lz_blank_gen`: combinational, computes the N_DIGITS effective-blank vector from the shadow digits, shadow mask and lz_suppress.
- All counters and the FSM stay in digit_scan_mux.

Test Plan:
All scenarios use N_DIGITS=4, DIGIT_W=4, REFRESH_DIV=8, DEAD_CYCLES=2, en=1, and count cycles from the first edge after rst falls.
1. Reset/dark frame: digits_in=0x4321, mask=0 -> an_n==4'b1111 for cycles 0..31; digit_idx steps 0,1,2,3 every 8 cycles; frame_tick=1 only at cycle 32.
2. Normal scan: same stimulus, frame starting at cycle 32 -> an_n=1111 at cycles 32-33, 1110 at cycles 34-39 with digit_out=1; then 1101/2, 1011/3, 0111/4 in the following slots, each with 2 dark cycles.
3. Tear-free update: change digits_in to 0x8765 at cycle 45 (mid-frame) -> digit_out keeps showing 0x4321 digits until cycle 64, then shows 5,6,7,8.
4. Leading-zero suppression: digits_in=0x0050, lz_suppress=1 -> digits 3 and 2 dark, digits 1 and 0 lit (digit 0 shows 0). With digits_in=0x0000, only digit 0 is lit.
5. Mask and freeze: blank_mask=4'b0100 -> slot 2 stays dark. Drop en for 20 cycles mid-ON -> an_n, cnt and idx hold, no frame_tick, and the slot resumes with its remaining cycles.
6. Async reset: assert rst between clock edges during slot 2 ON -> an_n goes to 1111 and digit_idx to 0 before the next clk edge; after release, behaviour matches scenario 1.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared types and helpers for the multiplexed display scanner
package display_pkg;

    typedef enum logic {BLANK, ON} scan_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lz_blank_gen.sv
// lz_blank_gen: per-digit effective blank from shadow mask plus leading-zero suppression
module lz_blank_gen #(
    parameter int N_DIGITS = 4,
    parameter int DIGIT_W  = 4
) (
    input  logic [N_DIGITS*DIGIT_W-1:0] digits,
    input  logic [N_DIGITS-1:0]         mask,
    input  logic                        lz_suppress,
    output logic [N_DIGITS-1:0]         blank
);

    logic all_zero;

    // walk from the most significant digit down; digit 0 is never suppressed
    always_comb begin
        all_zero = 1'b1;
        blank    = mask;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            all_zero = all_zero & (digits[k*DIGIT_W +: DIGIT_W] == '0);
            if (k > 0 && lz_suppress && all_zero)
                blank[k] = 1'b1;
        end
    end

endmodule

// File: rtl/digit_scan_mux.sv
// digit_scan_mux: time-multiplexed digit scanner with dead-time and frame-synchronous shadow load
module digit_scan_mux
    import display_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int DIGIT_W     = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [N_DIGITS*DIGIT_W-1:0]  digits_in,
    input  logic [N_DIGITS-1:0]          blank_mask,
    input  logic                         lz_suppress,
    output logic [N_DIGITS-1:0]          an_n,
    output logic [DIGIT_W-1:0]           digit_out,
    output logic [$clog2(N_DIGITS)-1:0]  digit_idx,
    output logic                         frame_tick
);

    localparam int IW = idx_w(N_DIGITS);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]       CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]       CNT_DEAD = CW'(DEAD_CYCLES);
    localparam logic [IW-1:0]       IDX_LAST = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_ONE   = N_DIGITS'(1);

    logic [CW-1:0]                cnt, cnt_n;
    logic [IW-1:0]                idx, idx_n;
    scan_state_t                  state, state_n;
    logic [N_DIGITS*DIGIT_W-1:0]  shadow, shadow_n;
    logic [N_DIGITS-1:0]          smask, smask_n, eff_blank;
    logic                         slot_end, frame_end;

    // outputs are registered from next-state values so they line up with cnt/idx/state
    always_comb begin
        slot_end  = en && cnt == CNT_LAST;
        frame_end = slot_end && idx == IDX_LAST;
        cnt_n     = !en ? cnt : slot_end ? '0 : cnt + 1'b1;
        idx_n     = !slot_end ? idx : frame_end ? '0 : idx + 1'b1;
        state_n   = !en ? state : cnt_n == CNT_DEAD ? ON : slot_end ? BLANK : state;
        shadow_n  = frame_end ? digits_in : shadow;
        smask_n   = frame_end ? blank_mask : smask;
    end

    lz_blank_gen #(
        .N_DIGITS (N_DIGITS),
        .DIGIT_W  (DIGIT_W)
    ) u_lz_blank_gen (
        .digits      (shadow_n),
        .mask        (smask_n),
        .lz_suppress (lz_suppress),
        .blank       (eff_blank)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            state      <= BLANK;
            shadow     <= '0;
            smask      <= '1;
            an_n       <= '1;
            digit_out  <= '0;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= cnt_n;
            idx        <= idx_n;
            state      <= state_n;
            shadow     <= shadow_n;
            smask      <= smask_n;
            frame_tick <= frame_end;
            if (en) begin
                an_n      <= (state_n == ON && !eff_blank[idx_n]) ? ~(AN_ONE << idx_n) : '1;
                digit_out <= shadow_n[idx_n*DIGIT_W +: DIGIT_W];
                digit_idx <= idx_n;
            end
        end
    end

endmodule

// File: tb/tb_digit_scan_mux.sv
// tb_digit_scan_mux: scoreboard bench for digit_scan_mux at N=4, W=4, DIV=8, DEAD=2
module tb_digit_scan_mux;

    localparam int N = 4;
    localparam int W = 4;
    localparam int R = 8;
    localparam int D = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b1;
    logic [N*W-1:0] digits_in = 16'h4321;
    logic [N-1:0]  blank_mask = 4'h0;
    logic          lz_suppress = 1'b0;
    logic [N-1:0]  an_n;
    logic [W-1:0]  digit_out;
    logic [1:0]    digit_idx;
    logic          frame_tick;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] dout;
        logic [1:0] didx;
        logic       ft;
    } exp_t;

    exp_t        q[$];
    exp_t        last;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          ft_cyc = -1;
    int          m_cnt, m_idx;
    logic [15:0] m_sh;
    logic [3:0]  m_mask;

    digit_scan_mux #(
        .N_DIGITS    (N),
        .DIGIT_W     (W),
        .REFRESH_DIV (R),
        .DEAD_CYCLES (D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .digits_in   (digits_in),
        .blank_mask  (blank_mask),
        .lz_suppress (lz_suppress),
        .an_n        (an_n),
        .digit_out   (digit_out),
        .digit_idx   (digit_idx),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic mblank(input int k);
        return m_mask[k] || (lz_suppress && k > 0 && (m_sh >> (4 * k)) == 16'h0);
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_idx = 0;
        m_sh = '0;
        m_mask = '1;
        last = '{an: 4'hf, dout: 4'h0, didx: 2'd0, ft: 1'b0};
        q.delete();
        cyc = 0;
        ft_cyc = -1;
    endtask

    task automatic step();
        exp_t e;
        logic wrapped;
        wrapped = 1'b0;
        if (en) begin
            if (m_cnt == R - 1) begin
                m_cnt = 0;
                if (m_idx == N - 1) begin
                    m_idx = 0;
                    m_sh = digits_in;
                    m_mask = blank_mask;
                    wrapped = 1'b1;
                end else
                    m_idx++;
            end else
                m_cnt++;
            e.an   = (m_cnt >= D && !mblank(m_idx)) ? ~(4'b0001 << m_idx) : 4'hf;
            e.dout = m_sh[m_idx*4 +: 4];
            e.didx = 2'(m_idx);
            e.ft   = wrapped;
            last   = e;
        end else begin
            e = last;
            e.ft = 1'b0;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = q.pop_front();
        if (frame_tick && ft_cyc < 0) ft_cyc = cyc;
        chk("an_n", 32'(an_n), 32'(e.an));
        chk("digit_out", 32'(digit_out), 32'(e.dout));
        chk("digit_idx", 32'(digit_idx), 32'(e.didx));
        chk("frame_tick", 32'(frame_tick), 32'(e.ft));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until(input string tag, input int idx, input int cnt);
        int i;
        for (i = 0; i < 200; i++) begin
            if (m_idx == idx && m_cnt == cnt) break;
            step();
        end
        chk(tag, 32'(i < 200), 32'd1);
    endtask

    initial begin
        model_reset();
        #22 rst = 1'b0;
        chk("rst_an", 32'(an_n), 32'hf);
        chk("rst_idx", 32'(digit_idx), 32'd0);
        chk("rst_dout", 32'(digit_out), 32'd0);
        chk("rst_ft", 32'(frame_tick), 32'd0);
        // dark first frame, then normal scan with a mid-frame update at cycle 45
        for (int c = 0; c < 96; c++) begin
            if (cyc == 45) digits_in = 16'h8765;
            step();
        end
        chk("first_ft", 32'(ft_cyc), 32'd32);
        // leading-zero suppression
        digits_in = 16'h0050;
        lz_suppress = 1'b1;
        run(64);
        digits_in = 16'h0000;
        run(64);
        // mask slot 2, freeze mid-ON and across frame boundaries
        lz_suppress = 1'b0;
        digits_in = 16'h4321;
        blank_mask = 4'b0100;
        run(64);
        run_until("wait_s1on", 1, 4);
        en = 1'b0;
        run(20);
        en = 1'b1;
        run_until("wait_s3end", 3, 7);
        en = 1'b0;
        run(20);
        en = 1'b1;
        step();
        en = 1'b0;
        run(5);
        en = 1'b1;
        run(40);
        // asynchronous reset in slot 2 ON
        run_until("wait_s2on", 2, 5);
        #3 rst = 1'b1;
        #1;
        chk("arst_an", 32'(an_n), 32'hf);
        chk("arst_idx", 32'(digit_idx), 32'd0);
        chk("arst_ft", 32'(frame_tick), 32'd0);
        model_reset();
        #2 rst = 1'b0;
        run(40);
        chk("rerst_ft", 32'(ft_cyc), 32'd32);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
